ins_cache_mw: RTL and testbench
===============================

# ins_cache_mw

Multi-window instruction cache controller sitting between the AP instruction decoder and the DDR read-burst port. It generalises the single-window, address-range-checked ISA buffer to `NUM_WIN` independently tagged windows plus one pinned interrupt window. It runs the hit check, the refill-length arithmetic and the DDR burst refill FSM, and returns one instruction per accepted request.

## Interface

**Parameters**

- `ISA_WIDTH`, default 30: instruction width (opcode + CAM addr + operand-2 + mem addr).
- `ADDR_WIDTH_MEM`, default 16: instruction address width. `INT_BASE = 1 << (ADDR_WIDTH_MEM-1)`.
- `DDR_ADDR_WIDTH`, default 28: DDR byte address width.
- `DDR_DATA_WIDTH`, default 64: burst beat width. Instruction = low `ISA_WIDTH` bits of a beat.
- `BYTE_SHIFT`, default 3: instruction address to DDR byte address shift.
- `WIN_DEPTH`, default 128: instructions per window. Power of two, ≤256.
- `NUM_WIN`, default 2: number of normal windows. Power of two, ≥1.
- `INT_INS_DEPTH`, default 27: interrupt window depth.

**Ports**

- `clk` input, 1: clock.
- `rst` input, 1: asynchronous reset, active-high.
- `ins_req` input, 1: fetch request.
- `addr_ins` input, `ADDR_WIDTH_MEM`: fetch address.
- `ins_ready` output, 1: request can be accepted.
- `ins_valid` output, 1: one-cycle response strobe.
- `ins_out` output, `ISA_WIDTH`: fetched instruction.
- `ins_err` output, 1: address beyond interrupt region. Qualified by `ins_valid`.
- `ic_flush` input, 1: invalidate all windows.
- `rd_burst_req` output, 1: one-cycle burst request.
- `rd_burst_addr` output, `DDR_ADDR_WIDTH`: burst byte address.
- `rd_burst_len` output, `$clog2(WIN_DEPTH)+1`: beats requested.
- `rd_burst_data_valid` input, 1: beat strobe.
- `rd_burst_data` input, `DDR_DATA_WIDTH`: beat data.
- `hit_cnt` output, 32: hit counter.
- `miss_cnt` output, 32: miss counter.

## Operation

- **FSM states:** IDLE, LOOKUP, REQ, FILL, RESP.
- **Accept:** `ins_ready = (state==IDLE) & !ic_flush & !flush_pend & !rst`. An accept (`ins_req & ins_ready`) registers `addr_ins` and moves IDLE→LOOKUP.
- **Normal-region hit** (A < INT_BASE): some valid window w satisfies `(A - tag[w]) < WIN_DEPTH`. The subtraction is unsigned, `ADDR_WIDTH_MEM+1` bits; a negative result is a miss. The lowest-index hitting window wins.
- **Interrupt-region hit:** `INT_BASE ≤ A < INT_BASE+INT_INS_DEPTH` and the interrupt window is valid.
- **Out-of-range address** (A ≥ INT_BASE+INT_INS_DEPTH): LOOKUP→RESP with `ins_err=1` and `ins_out=0`. No DDR access, no counter update.
- **Hit:** issue a storage read at `w*WIN_DEPTH + (A-tag)` (interrupt window at `NUM_WIN*WIN_DEPTH + (A-INT_BASE)`), then LOOKUP→RESP.
- **Miss, normal region:**
  - Victim = `rr_ptr`.
  - `rd_burst_addr = A << BYTE_SHIFT`.
  - `rd_burst_len = min(WIN_DEPTH, INT_BASE - A)`, so a window never crosses into the interrupt region.
  - The new tag is A.
- **Miss, interrupt region:**
  - `rd_burst_addr = INT_BASE << BYTE_SHIFT`.
  - `rd_burst_len = INT_INS_DEPTH`, regardless of the offset of A.
- **REQ:** assert `rd_burst_req` for exactly one cycle, then go to FILL.
- **FILL:** each `rd_burst_data_valid` beat writes the next entry, starting at offset 0.
  - After beat number `len`, set the tag and valid bit of the target window. For a normal victim, advance `rr_ptr` modulo `NUM_WIN`.
  - Go to LOOKUP. The replay is guaranteed to hit.
  - Beats arriving outside FILL are ignored.
- **RESP:** `ins_valid=1` for one cycle, then go to IDLE.
- **Flush:**
  - `ic_flush` in IDLE clears every valid bit and `rr_ptr` at the next edge. A simultaneous `ins_req` is not accepted.
  - `ic_flush` outside IDLE sets `flush_pend`. The pending flush is applied on RESP→IDLE, after the current response is delivered.

## Timing

- **Reset values:** state IDLE, `rr_ptr`=0, all valid bits 0, `flush_pend`=0. Outputs `ins_ready`=0 (while `rst` is high), `ins_valid`=0, `ins_out`=0, `ins_err`=0, `rd_burst_req`=0, `rd_burst_addr`=0, `rd_burst_len`=0, `hit_cnt`=0, `miss_cnt`=0. Storage contents are don't-care.
- **Hit latency:** accept at edge T. LOOKUP runs in cycle T+1. `ins_valid` is high in cycle T+2. `ins_ready` is high again in T+3. Hit throughput is 1 per 3 cycles.
- **Miss latency:** `rd_burst_req` is high in cycle T+2. After the last beat edge comes one LOOKUP cycle, then RESP.
- **Reset mid-FILL:** abandons the burst. Every window is invalid afterwards. Late beats are ignored in IDLE.

## Configuration

- Macro: `INS_CACHE_PERF_EN`.
- **Defined:** `hit_cnt` / `miss_cnt` increment, saturating at 0xFFFFFFFF, once per accepted in-range request, as decided in its first LOOKUP.
- **Undefined:** the counters are not built. The ports remain and are tied to 0.

## Structure

- **Package `ins_cache_pkg`:** FSM state enum, `INT_BASE` function, refill-length function `min(WIN_DEPTH, INT_BASE-A)`.
- **Sub-module `ins_cache_store`:** simple dual-port RAM, `NUM_WIN*WIN_DEPTH+INT_INS_DEPTH` × `ISA_WIDTH`, one write port, synchronous read.

## Test plan

All scenarios use the default parameters.

1. Reset, then request 0x0010 → one `rd_burst_req` pulse with addr 0x80, len 128. Drive 128 beats. `ins_valid` returns beat 0 with `ins_err`=0. `miss_cnt`=1.
2. Then request 0x008F → `ins_valid` at T+2 returning beat 127, no burst, `hit_cnt`=1. Request 0x0090 → miss filled into window 1.
3. Request 0x1000 → evicts window 0. A following request for 0x0010 misses again, burst addr 0x80.
4. Request 0x7FC0 → `rd_burst_len`=64, `rd_burst_addr`=0x3FE00.
5. Request 0x8005 → burst addr 0x40000, len 27, returns beat 5. Then request 0x801B → `ins_err`=1, no burst, counters unchanged.
6. Assert `rst` after beat 50 of a fill → all outputs return to reset values. Re-requesting the same address misses. `ic_flush` during that fill is applied after RESP, and the next request to the same address misses.

Source files
------------

// File: rtl/ins_cache_pkg.sv
// Shared types and arithmetic helpers for the multi-window instruction cache.
package ins_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_FILL,
    S_RESP
  } state_t;

  function automatic int unsigned int_base(input int unsigned addr_w);
    return 32'd1 << (addr_w - 1);
  endfunction

  // Normal windows are clipped so a refill never runs into the interrupt region.
  function automatic int unsigned refill_len(input int unsigned addr,
                                             input int unsigned addr_w,
                                             input int unsigned win_depth);
    int unsigned room;
    room = int_base(addr_w) - addr;
    return (room < win_depth) ? room : win_depth;
  endfunction

endpackage

// File: rtl/ins_cache_mw_if.sv
// Fetch, flush, DDR burst and statistics signals of ins_cache_mw.
interface ins_cache_mw_if #(
  parameter int unsigned ISA_WIDTH      = 30,
  parameter int unsigned ADDR_WIDTH_MEM = 16,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned DDR_DATA_WIDTH = 64,
  parameter int unsigned WIN_DEPTH      = 128
);
  localparam int unsigned LEN_W = $clog2(WIN_DEPTH) + 1;

  logic                      ins_req;
  logic [ADDR_WIDTH_MEM-1:0] addr_ins;
  logic                      ins_ready;
  logic                      ins_valid;
  logic [ISA_WIDTH-1:0]      ins_out;
  logic                      ins_err;
  logic                      ic_flush;
  logic                      rd_burst_req;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [LEN_W-1:0]          rd_burst_len;
  logic                      rd_burst_data_valid;
  logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
  logic [31:0]               hit_cnt;
  logic [31:0]               miss_cnt;

  modport slave (
    input  ins_req, addr_ins, ic_flush, rd_burst_data_valid, rd_burst_data,
    output ins_ready, ins_valid, ins_out, ins_err, rd_burst_req, rd_burst_addr,
           rd_burst_len, hit_cnt, miss_cnt
  );

  modport master (
    output ins_req, addr_ins, ic_flush, rd_burst_data_valid, rd_burst_data,
    input  ins_ready, ins_valid, ins_out, ins_err, rd_burst_req, rd_burst_addr,
           rd_burst_len, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/ins_cache_store.sv
// Simple dual-port instruction storage: one write port, registered read port.
module ins_cache_store #(
  parameter int unsigned DEPTH = 283,
  parameter int unsigned WIDTH = 30,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ins_cache_mw.sv
// Multi-window instruction cache: NUM_WIN round-robin windows plus a pinned interrupt window.
// Optional hit/miss counters are built when INS_CACHE_PERF_EN is defined.
module ins_cache_mw
  import ins_cache_pkg::*;
#(
  parameter int unsigned ISA_WIDTH      = 30,
  parameter int unsigned ADDR_WIDTH_MEM = 16,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned DDR_DATA_WIDTH = 64,
  parameter int unsigned BYTE_SHIFT     = 3,
  parameter int unsigned WIN_DEPTH      = 128,
  parameter int unsigned NUM_WIN        = 2,
  parameter int unsigned INT_INS_DEPTH  = 27
) (
  input  logic clk,
  input  logic rst,
  ins_cache_mw_if.slave bus
);
  localparam int unsigned AW       = ADDR_WIDTH_MEM;
  localparam int unsigned INT_BASE = int_base(AW);
  localparam int unsigned INT_END  = INT_BASE + INT_INS_DEPTH;
  localparam int unsigned LEN_W    = $clog2(WIN_DEPTH) + 1;
  localparam int unsigned OFF_W    = $clog2(WIN_DEPTH);
  localparam int unsigned RR_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int unsigned ST_DEPTH = NUM_WIN * WIN_DEPTH + INT_INS_DEPTH;
  localparam int unsigned SA_W     = $clog2(ST_DEPTH);

  state_t                    r_state, w_next;
  logic [AW-1:0]             r_addr;
  logic [NUM_WIN-1:0]        r_valid;
  logic [AW-1:0]             r_tag [NUM_WIN];
  logic                      r_int_valid;
  logic [RR_W-1:0]           r_rr_ptr;
  logic                      r_flush_pend;
  logic                      r_err;
  logic [DDR_ADDR_WIDTH-1:0] r_burst_addr;
  logic [LEN_W-1:0]          r_burst_len, r_fill_cnt, w_cnt_nxt;
  logic [SA_W-1:0]           r_fill_base, w_rd_addr;
  logic                      r_fill_int;
  logic [AW:0]               w_diff [NUM_WIN];
  logic                      w_normal, w_int_rgn, w_oor, w_hit;
  logic                      w_beat, w_last, w_accept, w_flush_now;
  logic                      w_ready, w_valid, w_burst_req, w_err_out;
  logic [ISA_WIDTH-1:0]      w_ins_out, w_rd_data;

  assign w_oor     = {1'b0, r_addr} >= (AW+1)'(INT_END);
  assign w_normal  = !r_addr[AW-1];
  assign w_int_rgn = r_addr[AW-1] && !w_oor;

  // Extra top bit makes an address below the tag wrap to a huge value, i.e. a miss.
  for (genvar g = 0; g < NUM_WIN; g++) begin : g_diff
    assign w_diff[g] = {1'b0, r_addr} - {1'b0, r_tag[g]};
  end

  always_comb begin
    w_hit     = 1'b0;
    w_rd_addr = SA_W'(NUM_WIN * WIN_DEPTH) + SA_W'(r_addr - AW'(INT_BASE));
    if (w_int_rgn) begin
      w_hit = r_int_valid;
    end else if (w_normal) begin
      for (int unsigned w = 0; w < NUM_WIN; w++) begin
        if (!w_hit && r_valid[w] && (w_diff[w] < (AW+1)'(WIN_DEPTH))) begin
          w_hit     = 1'b1;
          w_rd_addr = SA_W'(w * WIN_DEPTH) + SA_W'(w_diff[w][OFF_W-1:0]);
        end
      end
    end
  end

  assign w_beat      = (r_state == S_FILL) && bus.rd_burst_data_valid;
  assign w_cnt_nxt   = r_fill_cnt + LEN_W'(1);
  assign w_last      = w_beat && (w_cnt_nxt == r_burst_len);
  assign w_accept    = bus.ins_req && w_ready;
  assign w_flush_now = ((r_state == S_IDLE) && bus.ic_flush) ||
                       ((r_state == S_RESP) && (r_flush_pend || bus.ic_flush));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = (w_oor || w_hit) ? S_RESP : S_REQ;
      S_REQ:    w_next = S_FILL;
      S_FILL:   if (w_last) w_next = S_LOOKUP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == S_IDLE) && !bus.ic_flush && !r_flush_pend && !rst;
    w_valid     = (r_state == S_RESP);
    w_burst_req = (r_state == S_REQ);
    w_err_out   = w_valid && r_err;
    w_ins_out   = (w_valid && !r_err) ? w_rd_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_valid      <= '0;
      r_int_valid  <= 1'b0;
      r_rr_ptr     <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
      r_burst_addr <= '0;
      r_burst_len  <= '0;
      r_fill_cnt   <= '0;
      r_fill_base  <= '0;
      r_fill_int   <= 1'b0;
      for (int unsigned w = 0; w < NUM_WIN; w++) r_tag[w] <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) r_addr <= bus.addr_ins;
      if (r_state == S_LOOKUP) begin
        r_err <= w_oor;
        if (!w_oor && !w_hit) begin
          r_fill_cnt <= '0;
          r_fill_int <= w_int_rgn;
          if (w_int_rgn) begin
            r_burst_addr <= DDR_ADDR_WIDTH'(INT_BASE) << BYTE_SHIFT;
            r_burst_len  <= LEN_W'(INT_INS_DEPTH);
            r_fill_base  <= SA_W'(NUM_WIN * WIN_DEPTH);
          end else begin
            r_burst_addr <= DDR_ADDR_WIDTH'(r_addr) << BYTE_SHIFT;
            r_burst_len  <= LEN_W'(refill_len(32'(r_addr), AW, WIN_DEPTH));
            r_fill_base  <= SA_W'(32'(r_rr_ptr) * WIN_DEPTH);
          end
        end
      end
      if (w_beat) r_fill_cnt <= w_cnt_nxt;
      if (w_last) begin
        if (r_fill_int) begin
          r_int_valid <= 1'b1;
        end else begin
          r_valid[r_rr_ptr] <= 1'b1;
          r_tag[r_rr_ptr]   <= r_addr;
          r_rr_ptr <= (r_rr_ptr == RR_W'(NUM_WIN - 1)) ? '0 : r_rr_ptr + RR_W'(1);
        end
      end
      // A flush seen mid-transaction is deferred until its response has been delivered.
      if (bus.ic_flush && (r_state != S_IDLE) && (r_state != S_RESP)) r_flush_pend <= 1'b1;
      if (w_flush_now) begin
        r_valid      <= '0;
        r_int_valid  <= 1'b0;
        r_rr_ptr     <= '0;
        r_flush_pend <= 1'b0;
      end
    end
  end

  ins_cache_store #(
    .DEPTH (ST_DEPTH),
    .WIDTH (ISA_WIDTH),
    .AW    (SA_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_beat),
    .i_waddr (r_fill_base + SA_W'(r_fill_cnt)),
    .i_wdata (bus.rd_burst_data[ISA_WIDTH-1:0]),
    .i_re    (r_state == S_LOOKUP),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

`ifdef INS_CACHE_PERF_EN
  logic        r_first;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) r_first <= 1'b1;
      if (r_state == S_LOOKUP) begin
        r_first <= 1'b0;
        if (r_first && !w_oor) begin
          if (w_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
          end
        end
      end
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

  assign bus.ins_ready     = w_ready;
  assign bus.ins_valid     = w_valid;
  assign bus.ins_out       = w_ins_out;
  assign bus.ins_err       = w_err_out;
  assign bus.rd_burst_req  = w_burst_req;
  assign bus.rd_burst_addr = r_burst_addr;
  assign bus.rd_burst_len  = r_burst_len;
endmodule

// File: tb/tb_ins_cache_mw.sv
// Scoreboard bench for ins_cache_mw: directed scenarios plus random fetches against a window-list model.
module tb_ins_cache_mw;
  localparam int unsigned INT_BASE = 32'h8000;
  localparam int unsigned WIN      = 128;
  localparam int unsigned NW       = 2;
  localparam int unsigned IDEP     = 27;
`ifdef INS_CACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [29:0] data;
    logic        err;
    logic        hit;
    int unsigned acc;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  len;
    int unsigned acc;
  } burst_t;

  logic clk, rst;
  ins_cache_mw_if bus ();

  ins_cache_mw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  burst_t      bq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int          abort_at = -1;
  bit          aborted  = 0;
  bit          late_done = 0;

  int unsigned m_tag[NW];
  bit          m_val[NW];
  int unsigned m_rr;
  bit          m_int;
  int unsigned m_hit, m_miss;
  int unsigned last_tag = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_of(input int unsigned ia);
    logic [31:0] h;
    logic [31:0] a32;
    a32 = ia;
    h = ia * 32'h9E3779B9;
    h = h ^ (h >> 13);
    return {16'hC0DE, a32[15:0], h};
  endfunction

  function automatic void model_reset();
    for (int unsigned w = 0; w < NW; w++) m_val[w] = 1'b0;
    m_int = 1'b0;
    m_rr  = 0;
  endfunction

  // Reference: list of windows, each covering [tag, tag+WIN); interrupt window is all-or-nothing.
  task automatic model_req(input int unsigned a, input int unsigned acc);
    exp_t   e;
    burst_t b;
    logic [63:0] d;
    bit hit;
    bit err;
    hit = 1'b0;
    err = (a >= INT_BASE + IDEP);
    if (!err && a >= INT_BASE) begin
      hit = m_int;
      if (!hit) begin
        b.addr = 28'(INT_BASE * 8); b.len = 8'(IDEP); b.acc = acc; bq.push_back(b);
        m_int = 1'b1;
      end
    end else if (!err) begin
      for (int unsigned w = 0; w < NW; w++)
        if (m_val[w] && a >= m_tag[w] && a - m_tag[w] < WIN) hit = 1'b1;
      if (!hit) begin
        b.addr = 28'(a * 8);
        b.len  = 8'((INT_BASE - a < WIN) ? INT_BASE - a : WIN);
        b.acc  = acc;
        bq.push_back(b);
        m_tag[m_rr] = a; m_val[m_rr] = 1'b1; m_rr = (m_rr + 1) % NW;
        last_tag = a;
      end
    end
    if (!err) begin
      if (hit) m_hit++; else m_miss++;
    end
    d = beat_of(a);
    e.data = err ? 30'd0 : d[29:0];
    e.err  = err;
    e.hit  = hit;
    e.acc  = acc;
    e.hc   = PERF ? m_hit : 32'd0;
    e.mc   = PERF ? m_miss : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic wait_resp();
    int unsigned t = 0;
    while (sb_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("resp_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic issue(input int unsigned a, input bit wait_done);
    int unsigned t = 0;
    @(negedge clk);
    while (!bus.ins_ready && t < 2000) begin @(negedge clk); t++; end
    if (!bus.ins_ready) begin
      chk("ready_timeout", 64'(bus.ins_ready), 64'd1);
      return;
    end
    bus.ins_req  = 1'b1;
    bus.addr_ins = 16'(a);
    @(posedge clk);
    #1;
    bus.ins_req = 1'b0;
    model_req(a, cyc);
    if (wait_done) wait_resp();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.ins_ready), 64'd0);
    chk({tag, "_valid"}, 64'(bus.ins_valid), 64'd0);
    chk({tag, "_out"}, 64'(bus.ins_out), 64'd0);
    chk({tag, "_err"}, 64'(bus.ins_err), 64'd0);
    chk({tag, "_breq"}, 64'(bus.rd_burst_req), 64'd0);
    chk({tag, "_baddr"}, 64'(bus.rd_burst_addr), 64'd0);
    chk({tag, "_blen"}, 64'(bus.rd_burst_len), 64'd0);
    chk({tag, "_hit_cnt"}, 64'(bus.hit_cnt), 64'd0);
    chk({tag, "_miss_cnt"}, 64'(bus.miss_cnt), 64'd0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    bus.ic_flush = 1'b1;
    @(negedge clk);
    bus.ic_flush = 1'b0;
    model_reset();
  endtask

  // Response monitor
  initial begin
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ins_valid) begin
        chk("valid_one_cycle", 64'(prev_valid), 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ins_out", 64'(bus.ins_out), 64'(e.data));
          chk("ins_err", 64'(bus.ins_err), 64'(e.err));
          chk("hit_cnt", 64'(bus.hit_cnt), 64'(e.hc));
          chk("miss_cnt", 64'(bus.miss_cnt), 64'(e.mc));
          if (e.hit || e.err) chk("hit_latency", 64'(cyc - e.acc), 64'd1);
        end
      end
      prev_valid = !rst && bus.ins_valid;
    end
  end

  // DDR responder: checks each burst request, then streams beats with random gaps
  initial begin
    burst_t      eb;
    int unsigned base, len, t;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_burst_req) begin
        if (bq.size() == 0) begin
          chk("unexpected_burst", 64'd1, 64'd0);
        end else begin
          eb = bq.pop_front();
          chk("burst_addr", 64'(bus.rd_burst_addr), 64'(eb.addr));
          chk("burst_len", 64'(bus.rd_burst_len), 64'(eb.len));
          chk("burst_latency", 64'(cyc - eb.acc), 64'd1);
        end
        base = 32'(bus.rd_burst_addr) >> 3;
        len  = 32'(bus.rd_burst_len);
        @(negedge clk);
        for (int unsigned i = 0; i < len; i++) begin
          if (int'(i) == abort_at) begin
            aborted = 1'b1;
            t = 0;
            while (!rst && t < 1000) begin @(negedge clk); t++; end
            while (rst && t < 2000) begin @(negedge clk); t++; end
            for (int unsigned k = 0; k < 5; k++) begin
              bus.rd_burst_data       = beat_of(k);
              bus.rd_burst_data_valid = 1'b1;
              @(negedge clk);
              bus.rd_burst_data_valid = 1'b0;
            end
            abort_at  = -1;
            late_done = 1'b1;
            break;
          end
          repeat ($urandom_range(0, 1)) @(negedge clk);
          bus.rd_burst_data       = beat_of(base + i);
          bus.rd_burst_data_valid = 1'b1;
          @(negedge clk);
          bus.rd_burst_data_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, r, t;
    bus.ins_req  = 1'b0;
    bus.addr_ins = '0;
    bus.ic_flush = 1'b0;
    model_reset();
    m_hit = 0; m_miss = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed scenarios
    issue(32'h0010, 1);
    issue(32'h008F, 1);
    issue(32'h0090, 1);
    issue(32'h1000, 1);
    issue(32'h0010, 1);
    issue(32'h7FC0, 1);
    issue(32'h8005, 1);
    issue(32'h801B, 1);
    issue(32'h8000, 1);
    issue(32'h801A, 1);
    issue(32'h7FFF, 1);
    issue(32'h0090, 1);
    issue(32'hFFFF, 1);

    // Flush in IDLE blocks a simultaneous request
    @(negedge clk);
    bus.ic_flush = 1'b1;
    bus.ins_req  = 1'b1;
    bus.addr_ins = 16'h7FC0;
    #1;
    chk("ready_during_flush", 64'(bus.ins_ready), 64'd0);
    @(negedge clk);
    bus.ic_flush = 1'b0;
    bus.ins_req  = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    issue(32'h7FC0, 1);
    issue(32'h8003, 1);

    // Flush during a fill takes effect only after the response
    issue(32'h2000, 0);
    repeat (20) @(negedge clk);
    bus.ic_flush = 1'b1;
    @(negedge clk);
    bus.ic_flush = 1'b0;
    wait_resp();
    model_reset();
    issue(32'h2000, 1);

    // Reset in the middle of a fill
    abort_at = 50;
    issue(32'h3000, 0);
    t = 0;
    while (!aborted && t < 5000) begin @(negedge clk); t++; end
    chk("abort_reached", 64'(aborted), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midfill_rst");
    sb_q.delete();
    model_reset();
    m_hit = 0; m_miss = 0;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (!late_done && t < 5000) begin @(negedge clk); t++; end
    chk("late_beats_done", 64'(late_done), 64'd1);
    issue(32'h3000, 1);
    issue(32'h3001, 1);

    // Random traffic
    for (int unsigned n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      a = (last_tag + $urandom_range(0, 150)) & 32'hFFFF;
      else if (r < 6) a = $urandom_range(0, 32'h7FFF);
      else if (r < 8) a = INT_BASE + $urandom_range(0, 30);
      else            a = 32'h7F80 + $urandom_range(0, 127);
      issue(a, 1);
      if ($urandom_range(0, 9) == 0) flush_idle();
    end

    repeat (5) @(negedge clk);
    chk("burst_queue_empty", 64'(bq.size()), 64'd0);
    chk("sb_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
